// File: rtl/gf8_pkg.sv
// Shared constants and helpers for the GF(2^8) serial datapath.
// Operand selection and the per-bit multiplier-row function live here.
package gf8_pkg;
  localparam int GF_W         = 8;
  localparam logic [7:0] AES_POLY = 8'h1B;
  localparam int NUM_OPS      = 14;
  localparam int SERIAL_STEPS = 8;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ZERO = 3'd1;
  localparam logic [2:0] ST_LOAD = 3'd2;
  localparam logic [2:0] ST_RUN  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [1:0] Y_R = 2'd0;
  localparam logic [1:0] Y_B = 2'd1;
  localparam logic [1:0] Y_A = 2'd2;

  // x operand is always the running value r; only y varies per op.
  function automatic logic [1:0] op_ysel(input logic [3:0] op);
    logic [1:0] s;
    if (op == 4'd13)      s = Y_A;
    else if (op == 4'd12) s = Y_R;
    else if (op[0])       s = Y_B;
    else                  s = Y_R;
    return s;
  endfunction

  function automatic logic [7:0] gf_step(input logic [7:0] p, input logic [7:0] x,
                                         input logic [7:0] g, input logic ybit);
    return {p[6:0], 1'b0} ^ (ybit ? x : 8'h00) ^ (p[7] ? g : 8'h00);
  endfunction
endpackage

// File: rtl/gf8_serial_mul.sv
// Bit-serial GF(2^8) multiplier, one array row per cycle, MSB of y first.
// load captures operands and clears p; ready is high during the 8th step.
import gf8_pkg::*;

module gf8_serial_mul (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [GF_W-1:0] x,
  input  logic [GF_W-1:0] y,
  input  logic [GF_W-1:0] g,
  output logic [GF_W-1:0] p,
  output logic            ready
);
  logic [GF_W-1:0] xr, yr, gr;
  logic [2:0]      cnt;
  logic            act;

  assign ready = act && (cnt == 3'(SERIAL_STEPS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xr  <= '0;
      yr  <= '0;
      gr  <= '0;
      p   <= '0;
      cnt <= '0;
      act <= 1'b0;
    end else if (load) begin
      xr  <= x;
      yr  <= y;
      gr  <= g;
      p   <= '0;
      cnt <= '0;
      act <= 1'b1;
    end else if (act) begin
      p   <= gf_step(p, xr, gr, yr[GF_W-1]);
      yr  <= {yr[GF_W-2:0], 1'b0};
      cnt <= cnt + 3'd1;
      if (ready) act <= 1'b0;
    end
  end
endmodule

// File: rtl/gf8_serial_divider.sv
// GF(2^8) divider q = a * b^254 via 14 serial multiplies; done LAT cycles after accept.
// The accept cycle doubles as the load slot of the first multiply.
import gf8_pkg::*;

module gf8_serial_divider #(
  parameter int LAT = NUM_OPS * (SERIAL_STEPS + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [GF_W-1:0] a,
  input  logic [GF_W-1:0] b,
  input  logic [GF_W-1:0] g,
  output logic            busy,
  output logic            done,
  output logic [GF_W-1:0] q,
  output logic            div_by_zero
);
  logic [2:0]      state;
  logic [3:0]      op;
  logic [GF_W-1:0] a_r, b_r, g_r;
  logic            accept;
  logic            mul_load, mul_ready;
  logic [GF_W-1:0] mul_x, mul_y, mul_g, mul_p;

  assign busy   = (state != ST_IDLE) || done;
  assign accept = start && !busy;

  // r lives in the multiplier accumulator between ops; op 0 starts from b.
  always_comb begin
    mul_load = (accept && (b != '0)) || (state == ST_LOAD);
    mul_x    = mul_p;
    mul_g    = g_r;
    mul_y    = mul_p;
    if (accept) begin
      mul_x = b;
      mul_y = b;
      mul_g = g;
    end else begin
      case (op_ysel(op))
        Y_B:     mul_y = b_r;
        Y_A:     mul_y = a_r;
        default: mul_y = mul_p;
      endcase
    end
  end

  gf8_serial_mul u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (mul_load),
    .x     (mul_x),
    .y     (mul_y),
    .g     (mul_g),
    .p     (mul_p),
    .ready (mul_ready)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      op          <= '0;
      a_r         <= '0;
      b_r         <= '0;
      g_r         <= '0;
      q           <= '0;
      div_by_zero <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            a_r   <= a;
            b_r   <= b;
            g_r   <= g;
            op    <= '0;
            state <= (b == '0) ? ST_ZERO : ST_RUN;
          end
        end
        ST_ZERO: begin
          done        <= 1'b1;
          q           <= '0;
          div_by_zero <= 1'b1;
          state       <= ST_IDLE;
        end
        ST_RUN: begin
          if (mul_ready) begin
            if (op == 4'(NUM_OPS - 1)) begin
              state <= ST_DONE;
            end else begin
              op    <= op + 4'd1;
              state <= ST_LOAD;
            end
          end
        end
        ST_LOAD: state <= ST_RUN;
        ST_DONE: begin
          done        <= 1'b1;
          q           <= mul_p;
          div_by_zero <= 1'b0;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gf8_serial_divider.sv
// Random and directed checks of gf8_serial_divider against a field-arithmetic model.
module tb_gf8_serial_divider;
  logic       clk = 1'b0;
  logic       rst_n, start, busy, done, div_by_zero;
  logic [7:0] a, b, g, q;
  int         checks = 0;
  int         errors = 0;

  localparam int LAT = 126;
  logic [7:0] polys [15] = '{8'h1B, 8'h1D, 8'h2B, 8'h2D, 8'h39, 8'h3F, 8'h4D, 8'h5F,
                             8'h63, 8'h65, 8'h69, 8'h71, 8'h77, 8'h7B, 8'h87};

  always #5 clk = ~clk;

  gf8_serial_divider dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .g(g),
    .busy(busy), .done(done), .q(q), .div_by_zero(div_by_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Shift-and-add product, LSB first, reducing modulo x^8 + g.
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y, input logic [7:0] gp);
    logic [7:0] r, t;
    r = 8'h00;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) r ^= t;
      t = t[7] ? ((t << 1) ^ gp) : (t << 1);
    end
    return r;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] x, input logic [7:0] gp);
    logic [7:0] yy;
    for (int k = 1; k < 256; k++) begin
      yy = k[7:0];
      if (gmul(x, yy, gp) == 8'h01) return yy;
    end
    return 8'h00;
  endfunction

  task automatic do_div(input logic [7:0] ta, input logic [7:0] tb, input logic [7:0] tg,
                        input bit inject, output logic [7:0] oq, output logic odz, output int lat);
    bit busy_ok;
    a = ta; b = tb; g = tg; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 300) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      a = 8'($urandom); b = 8'($urandom); g = 8'($urandom);
      start = (inject && lat == 9) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk("busy_during_op", {31'd0, busy_ok}, 32'd1);
    chk("busy_at_done", {31'd0, busy}, 32'd1);
    oq = q;
    odz = div_by_zero;
    start = inject;
    a = 8'($urandom); b = 8'h07;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_drop", {30'd0, busy, done}, 32'd0);
    @(posedge clk); #1;
    chk("idle_after", {31'd0, busy}, 32'd0);
    chk("q_held", {24'd0, q}, {24'd0, oq});
  endtask

  task automatic run_case(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                          input logic [7:0] tg, input bit inject);
    logic [7:0] rq, eq;
    logic       rdz;
    int         rlat;
    eq = (tb == 8'h00) ? 8'h00 : gmul(ta, ginv(tb, tg), tg);
    do_div(ta, tb, tg, inject, rq, rdz, rlat);
    chk({tag, "_q"}, {24'd0, rq}, {24'd0, eq});
    chk({tag, "_dz"}, {31'd0, rdz}, {31'd0, tb == 8'h00});
    chk({tag, "_lat"}, rlat, (tb == 8'h00) ? 1 : LAT);
  endtask

  initial begin
    logic [7:0] ra, rb, rg;
    bit         saw_done;
    rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00; g = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", {21'd0, busy, done, div_by_zero, q}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Known field values double-check the model itself.
    chk("model_inv53", {24'd0, ginv(8'h53, 8'h1B)}, 32'hCA);
    chk("model_inv02_1d", {24'd0, ginv(8'h02, 8'h1D)}, 32'h8E);

    run_case("aes_53", 8'h01, 8'h53, 8'h1B, 1'b1);
    run_case("aes_c1_83", 8'hC1, 8'h83, 8'h1B, 1'b0);
    run_case("aes_inv02", 8'h01, 8'h02, 8'h1B, 1'b0);
    run_case("poly1d", 8'h01, 8'h02, 8'h1D, 1'b0);
    run_case("bzero", 8'h5A, 8'h00, 8'h1B, 1'b1);
    run_case("bone", 8'h5A, 8'h01, 8'h1B, 1'b0);
    run_case("azero", 8'h00, 8'h37, 8'h1B, 1'b0);

    for (int n = 0; n < 24; n++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      rg = polys[$urandom_range(0, 14)];
      run_case("rand", ra, rb, rg, n[0]);
    end

    // Abort mid-operation with reset, then confirm a clean restart.
    a = 8'h11; b = 8'h22; g = 8'h1B; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (59) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midreset_out", {21'd0, busy, done, div_by_zero, q}, 32'd0);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (140) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    chk("midreset_nodone", {31'd0, saw_done}, 32'd0);
    run_case("after_reset", 8'hC1, 8'h83, 8'h1B, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gf8_serial_divider.md
Name: gf8_serial_divider

Overview:
- Sequential GF(2^8) divider; computes q = a / b = a * b^-1 over a runtime-selectable field polynomial.
- Inverse direction of the existing systolic multiplier array.
- Inversion by Fermat square-and-multiply, b^-1 = b^254.
- Reuses the multiplier-row arithmetic as a bit-serial, one-row-per-cycle multiplier. Sits beside the array for division and normalisation operations.

Parameters:
- LAT, 126, fixed cycles from start capture to done (14 multiplies x 9 cycles); informational, must match RTL.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request pulse; accepted only when busy=0
- a  input  8  dividend, a[7]=x^7 coefficient
- b  input  8  divisor
- g  input  8  field polynomial low coefficients g7..g0 (x^8 implicit; AES=8'h1B)
- busy  output  1  high from accept edge until done cycle inclusive
- done  output  1  one-cycle pulse, q/div_by_zero valid
- q  output  8  quotient; held until next accepted start
- div_by_zero  output  1  set with done when b==0; held with q

Behaviour:
- Reset (rst_n=0 at clock edge): busy=0, done=0, q=0, div_by_zero=0, FSM=IDLE, multiplier cleared. Reset mid-operation aborts immediately; no done is produced.
- Accept: start=1 and busy=0 at edge E0. a, b, g are captured into registers; later input changes are ignored. start while busy=1 is ignored (no queueing).
- Zero divisor: b==0 at accept. Next cycle: done=1, q=0, div_by_zero=1, busy=0 after that cycle. Latency 1.
- Otherwise div_by_zero=0 and r=b. The FSM issues 14 serial multiplies, in order:
  - SQR: r=r*r, then MULB: r=r*b; repeated 6 times (r reaches b^127).
  - FINSQR: r=r*r (r = b^254 = b^-1).
  - MULA: q=r*a.
- FSM states: IDLE, ZERO, LOAD, RUN, DONE. LOAD selects operands for the next op; RUN lasts 8 cycles. An op counter (0..13) selects the operand pair.
- Serial multiply x*y, MSB-first, 8 iterations with p=0 initially. Each iteration: p <= {p[6:0],0} ^ (y[i] ? x : 0) ^ (p[7] ? g : 0), i=7..0. Identical per-bit function to one multiplier-array row.
- Timing: each op = 1 LOAD + 8 RUN cycles. done is high exactly LAT=126 cycles after E0; busy falls the following cycle.
- done and a new start in the same cycle: start is ignored (busy still 1).
- b==1: q=a (natural result, no special case). a==0, b!=0: q=0, div_by_zero=0.

Decomposition:
- Shared package gf8_pkg:
  - GF_W=8, AES_POLY=8'h1B, NUM_OPS=14, SERIAL_STEPS=8, state enum.
  - Op-table function returning the operand pair per op index.
- Sub-module gf8_serial_mul:
  - Ports: clk, rst_n, load, x, y, g, p, ready.
  - 3-bit step counter; ready pulses on the 8th step.
  - The divider FSM sequences it.

Test Plan:
- g=8'h1B, a=8'h01, b=8'h53 -> after 126 cycles done=1, q=8'hCA, div_by_zero=0; busy high for cycles 1..126.
- g=8'h1B, a=8'hC1, b=8'h83 -> q=8'h57. Also a=8'h01, b=8'h02 -> q=8'h8D.
- g=8'h1D, a=8'h01, b=8'h02 -> q=8'h8E (polynomial taken from port, not hardwired).
- b=8'h00, a=8'h5A -> done one cycle after accept, q=8'h00, div_by_zero=1. b=8'h01, a=8'h5A -> q=8'h5A.
- Start pulsed again at cycles 10 and 126 with different a/b -> ignored, first result unchanged. Start changing inputs mid-run -> result uses captured values.
- rst_n=0 at cycle 60 -> all outputs 0 next edge, no done. A fresh start then completes normally in 126 cycles.
